cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache miss path and the D-cache miss/writeback path of the RV32I pipeline.
- Sits between the two caches (behind the datapath's inst_* and data_* ports) and main memory.
- Grants one line transaction at a time and latches its address and write data.
- Priority goes to the D-cache, with a bounded starvation guard for the I-cache.

Parameters:
- LINE_W, 256, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D grants made while I is pending before I is forced; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_addr  in  32  I-cache line address (line-aligned).
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- i_rdata  out  LINE_W  line returned to the I-cache; valid while i_resp=1.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line writeback request; held until d_resp.
- d_addr  in  32  D-cache line address.
- d_wdata  in  LINE_W  writeback line.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- d_rdata  out  LINE_W  line returned to the D-cache; valid while d_resp=1.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  32  memory line address.
- mem_wdata  out  LINE_W  memory write line.
- mem_resp  in  1  memory completion pulse.
- mem_rdata  in  LINE_W  memory read line; valid while mem_resp=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, starve_cnt=0, latched addr/wdata/op cleared.
  - All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, i_resp, d_resp, i_rdata, d_rdata.
  - Reset asserted mid-transaction aborts the transaction. No resp is issued, and the mem request drops immediately.
- States:
  - IDLE: no transaction in flight.
  - SERVE_I: serving an I-cache read.
  - SERVE_D: serving a D-cache read or writeback.
  - DONE: one-cycle cooldown after a response.
- IDLE arbitration, evaluated each cycle:
  - Requests present: i_pend=i_read; d_pend=d_read|d_write.
  - I is forced when i_pend and d_pend are both set and starve_cnt==STARVE_LIMIT. Next state is SERVE_I.
  - Otherwise, if d_pend, next state is SERVE_D.
  - Otherwise, if i_pend, next state is SERVE_I.
  - Otherwise, stay in IDLE.
- Grant capture (at the IDLE→SERVE_x edge): address, op and wdata are latched from the granted requester. mem_* are driven from these registers only.
  - Latency: request seen in cycle N gives mem_read or mem_write = 1 in cycle N+1.
  - Requester inputs changing during SERVE_x have no effect.
- d_read and d_write both asserted is a protocol violation. Writeback takes precedence, and a simulation-only assertion fires.
- In SERVE_x, the mem request is held high until mem_resp=1. In that same cycle:
  - The matching x_resp=1 and x_rdata=mem_rdata, combinationally.
  - For a writeback, d_rdata is don't-care and is driven 0.
  - Next state is DONE. The mem request deasserts in the DONE cycle.
- DONE: all requests are ignored for exactly one cycle so the requester can drop its stale read/write. Next state is IDLE.
- Back-to-back cost: minimum 2 idle cycles on mem_* between transactions (the DONE cycle and the IDLE grant cycle).
- starve_cnt is updated at the grant edge:
  - D grant with i_pend=1: increment, saturating at STARVE_LIMIT.
  - I grant: clear to 0.
  - D grant with i_pend=0: clear to 0.
- mem_resp outside SERVE_x is ignored and produces no resp output.
- At most one of i_resp and d_resp is high in any cycle. They are never both high.
- Width rules:
  - starve_cnt is $clog2(STARVE_LIMIT+1) bits.
  - Addresses are passed unmodified; the arbiter does not align them.

Decomposition:
- Shared package (cache_arb_types): enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE}, plus enum arb_op_t {OP_NONE, OP_READ, OP_WRITE}.
- No sub-module. The arbitration decision is a small always_comb inside the block, and the FSM, counter and latches are single-module.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_0040 in cycle 0; memory responds in cycle 5 with 0xAA..AA.
  - Cycle 1: mem_read=1, mem_addr=0x40.
  - Cycle 5: i_resp=1, i_rdata=0xAA..AA, d_resp=0.
  - Cycle 6: DONE, mem_read=0.
- Simultaneous requests: i_read and d_write asserted together with d_addr=0x100, d_wdata=0x55..55.
  - D is granted first: mem_write=1, mem_addr=0x100, mem_wdata=0x55..55.
  - After d_resp, I is granted within 2 cycles.
- Starvation guard (STARVE_LIMIT=4): hold i_read=1 while issuing 6 consecutive D reads.
  - Grants 1–4 go to D; grant 5 goes to I; starve_cnt returns to 0.
- Input stability: change d_addr from 0x200 to 0x300 during SERVE_D.
  - mem_addr stays 0x200 until mem_resp.
- Cooldown and stray response: keep d_read=1 in the DONE cycle.
  - No new grant occurs in DONE.
  - A mem_resp pulse while IDLE yields no i_resp or d_resp.
- Reset mid-transaction: pull rst=0 in SERVE_I before mem_resp.
  - mem_read=0 immediately, with no resp issued.
  - After release, state is IDLE and starve_cnt=0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache line-port arbiter.
package cache_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates the single memory line port between I-cache reads and D-cache reads/writebacks.
// D-cache has priority; a saturating counter forces an I grant after STARVE_LIMIT D grants.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_op_t          op_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_pend;
  logic             d_pend;
  logic             starved;
  logic             grant_i;
  logic             grant_d;
  logic             serving;

  // Grant decision, only meaningful while IDLE.
  always_comb begin
    i_pend  = i_read;
    d_pend  = d_read | d_write;
    starved = i_pend && d_pend && (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (starved)     grant_i = 1'b1;
      else if (d_pend) grant_d = 1'b1;
      else if (i_pend) grant_i = 1'b1;
    end
  end

  assign serving = (state == SERVE_I) || (state == SERVE_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state plus the combinational response path back to the caches.
  always_comb begin
    state_nxt = state;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_resp    = 1'b1;
          i_rdata   = mem_rdata;
          state_nxt = DONE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_resp    = 1'b1;
          if (op_q == OP_READ) d_rdata = mem_rdata;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture: mem_* come only from these registers so requester changes cannot leak through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_NONE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else if (grant_i) begin
      op_q       <= OP_READ;
      mem_read   <= 1'b1;
      mem_write  <= 1'b0;
      mem_addr   <= i_addr;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else if (grant_d) begin
      op_q      <= d_write ? OP_WRITE : OP_READ;
      mem_read  <= ~d_write;
      mem_write <= d_write;
      mem_addr  <= d_addr;
      mem_wdata <= d_write ? d_wdata : '0;
      if (!i_pend)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end else if (serving && mem_resp) begin
      op_q      <= OP_NONE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Read and writeback together is a requester bug; writeback wins in the grant above.
  rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with hand-computed expectations.
module tb_cache_arbiter;
  import cache_arb_types::*;

  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [31:0]       i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the DONE cycle.
  task automatic txn(input string tag, input logic exp_i, input logic exp_wr,
                     input logic [31:0] exp_addr, input logic [LINE_W-1:0] exp_wdata,
                     input logic [LINE_W-1:0] rdata, input int lat);
    tick();
    @(negedge clk);
    chk({tag, "_mem_read"},  LINE_W'(mem_read),  LINE_W'(!exp_wr));
    chk({tag, "_mem_write"}, LINE_W'(mem_write), LINE_W'(exp_wr));
    chk({tag, "_mem_addr"},  LINE_W'(mem_addr),  LINE_W'(exp_addr));
    if (exp_wr) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    for (int k = 0; k < lat; k++) begin
      tick();
      @(negedge clk);
      chk({tag, "_held"}, LINE_W'(mem_read | mem_write), LINE_W'(1));
    end
    tick();
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    chk({tag, "_i_resp"},  LINE_W'(i_resp), LINE_W'(exp_i));
    chk({tag, "_d_resp"},  LINE_W'(d_resp), LINE_W'(!exp_i));
    chk({tag, "_i_rdata"}, i_rdata, exp_i ? rdata : '0);
    chk({tag, "_d_rdata"}, d_rdata, (!exp_i && !exp_wr) ? rdata : '0);
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  // Checks the DONE cycle is quiet, then advances to the IDLE cycle.
  task automatic done_chk(input string tag);
    @(negedge clk);
    chk({tag, "_done_req"},  LINE_W'(mem_read | mem_write), LINE_W'(0));
    chk({tag, "_done_resp"}, LINE_W'(i_resp | d_resp), LINE_W'(0));
    tick();
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_5;
    logic [LINE_W-1:0] pat_c;
    logic [31:0]       d_base;
    int                exp_cnt [6];
    int                dcount;

    pat_a = {32{8'hAA}};
    pat_5 = {32{8'h55}};
    pat_c = {32{8'hC3}};
    exp_cnt = '{1, 2, 3, 4, 0, 0};

    rst = 1'b0; i_read = 1'b1; i_addr = 32'h40; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;

    // Held in reset with a pending request: everything stays low.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_read", LINE_W'(mem_read), LINE_W'(0));
    chk("rst_mem_addr", LINE_W'(mem_addr), LINE_W'(0));
    chk("rst_i_resp",   LINE_W'(i_resp),   LINE_W'(0));
    i_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // I-only read: request cycle 0, response cycle 5.
    i_read = 1'b1; i_addr = 32'h0000_0040;
    txn("i_only", 1'b1, 1'b0, 32'h40, '0, pat_a, 3);
    i_read = 1'b0;
    done_chk("i_only");

    // Simultaneous I read and D writeback: D first, then I after two quiet cycles.
    i_read = 1'b1; i_addr = 32'h80;
    d_write = 1'b1; d_addr = 32'h100; d_wdata = pat_5;
    txn("simul_d", 1'b0, 1'b1, 32'h100, pat_5, pat_c, 0);
    d_write = 1'b0;
    done_chk("simul_d");
    @(negedge clk);
    chk("simul_grant_idle", LINE_W'(mem_read | mem_write), LINE_W'(0));
    txn("simul_i", 1'b1, 1'b0, 32'h80, '0, pat_a, 0);
    i_read = 1'b0;
    done_chk("simul_i");

    // Starvation guard: I held while D keeps missing.
    d_base = 32'h1000;
    dcount = 0;
    i_read = 1'b1; i_addr = 32'h400;
    d_read = 1'b1; d_addr = d_base;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        txn($sformatf("starve_g%0d", g), 1'b1, 1'b0, 32'h400, '0, pat_a, 1);
        i_read = 1'b0;
      end else begin
        txn($sformatf("starve_g%0d", g), 1'b0, 1'b0, d_base + 32'(dcount * 'h40), '0, pat_5, 1);
        dcount++;
        d_addr = d_base + 32'(dcount * 'h40);
      end
      chk($sformatf("starve_cnt_g%0d", g), LINE_W'(dut.starve_cnt), LINE_W'(exp_cnt[g]));
      if (g == 5) d_read = 1'b0;
      done_chk($sformatf("starve_g%0d", g));
    end

    // Input stability, cooldown and stray response.
    d_read = 1'b1; d_addr = 32'h200;
    tick();
    d_addr = 32'h300;
    @(negedge clk);
    chk("stable_addr0", LINE_W'(mem_addr), LINE_W'(32'h200));
    tick();
    @(negedge clk);
    chk("stable_addr1", LINE_W'(mem_addr), LINE_W'(32'h200));
    tick();
    mem_resp = 1'b1; mem_rdata = pat_c;
    @(negedge clk);
    chk("stable_d_resp",  LINE_W'(d_resp),   LINE_W'(1));
    chk("stable_d_rdata", d_rdata,           pat_c);
    chk("stable_addr2",   LINE_W'(mem_addr), LINE_W'(32'h200));
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("cool_done_req", LINE_W'(mem_read), LINE_W'(0));
    tick();
    d_read = 1'b0;
    @(negedge clk);
    chk("cool_no_grant", LINE_W'(mem_read | mem_write), LINE_W'(0));
    mem_resp = 1'b1; mem_rdata = pat_a;
    #1;
    chk("stray_i_resp", LINE_W'(i_resp), LINE_W'(0));
    chk("stray_d_resp", LINE_W'(d_resp), LINE_W'(0));
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("stray_no_req", LINE_W'(mem_read | mem_write), LINE_W'(0));
    tick();

    // Reset in the middle of an I read.
    i_read = 1'b1; i_addr = 32'h500;
    tick();
    @(negedge clk);
    chk("rstmid_req", LINE_W'(mem_read), LINE_W'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_drop", LINE_W'(mem_read), LINE_W'(0));
    chk("rstmid_addr", LINE_W'(mem_addr), LINE_W'(0));
    mem_resp = 1'b1; mem_rdata = pat_a;
    #1;
    chk("rstmid_no_resp", LINE_W'(i_resp | d_resp), LINE_W'(0));
    mem_resp = 1'b0; i_read = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_state", LINE_W'(dut.state),      LINE_W'(IDLE));
    chk("rstmid_cnt",   LINE_W'(dut.starve_cnt), LINE_W'(0));
    tick();

    // Normal operation resumes after reset.
    d_read = 1'b1; d_addr = 32'h600;
    txn("post_rst", 1'b0, 1'b0, 32'h600, '0, pat_5, 0);
    d_read = 1'b0;
    done_chk("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
